mips_register_file: RTL and testbench
=====================================

Name: mips_register_file

Overview:
- 32 x 32-bit general-purpose register file for the 32-bit MIPS datapath.
- Sits directly upstream of the 32-bit 2:1 operand mux:
  - read_data2 is mux input 0.
  - The sign-extended immediate is mux input 1.
  - The ALUSrc control drives the select.
- Provides two combinational read ports and one clocked write port.
- Same-cycle write-to-read bypass, so the operand mux never sees stale data.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers (2**ADDR_W).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- read_reg1  input  ADDR_W  rs address.
- read_reg2  input  ADDR_W  rt address.
- write_reg  input  ADDR_W  destination address (rd or rt, selected upstream).
- write_data  input  DATA_W  value to write.
- reg_write  input  1  write enable.
- read_data1  output  DATA_W  contents of read_reg1, feeds ALU operand A.
- read_data2  output  DATA_W  contents of read_reg2, feeds operand 2:1 mux input 0.
- write_ack  output  1  registered pulse, high for one cycle after a write commits to a register other than $0.

Behaviour:
- Reset:
  - reset_n low clears all NUM_REGS registers to 0 immediately, without waiting for clk.
  - write_ack = 0.
  - read_data1 and read_data2 = 0 while reset is held.
- Reset release:
  - The first write can occur on the first rising clk edge where reset_n = 1.
  - Deassertion is not synchronised internally; the system reset controller releases reset away from clk edges.
- Write:
  - On posedge clk with reset_n = 1 and reg_write = 1, regs[write_reg] <= write_data.
  - Write latency is 1 cycle.
- Register $0:
  - Hardwired zero: writes to address 0 are ignored.
  - Reads of address 0 always return 0.
  - write_ack is not asserted for writes to address 0.
- Read:
  - Purely combinational from address to data (0-cycle latency).
- Bypass:
  - If reg_write = 1, write_reg != 0 and write_reg == read_regN in the same cycle, read_dataN = write_data combinationally.
  - This applies before the edge; after the edge the stored value matches anyway.
  - Bypass applies independently to both ports.
  - Both ports may bypass simultaneously when read_reg1 == read_reg2 == write_reg.
- write_ack:
  - write_ack <= reg_write & (write_reg != 0) on each posedge.
  - Back-to-back writes hold write_ack high continuously.
- Reset mid-operation:
  - Asserting reset_n in the same cycle as a pending write discards the write.
  - The register reads 0 after reset.
- No X propagation:
  - Any address value 0..31 is legal.
  - No undefined state exists beyond reset.
- Arithmetic: none. Data is stored and returned bit-exact; there is no sign handling.

Test Plan:
- Reset then read: assert reset_n = 0 for 20 ns, release, read_reg1 = 5, read_reg2 = 31 -> read_data1 = read_data2 = 32'h00000000, write_ack = 0.
- Write then read: write 32'h0F0F0F0F to reg 8 and 32'hF0F0F0F0 to reg 9 on consecutive edges -> read_reg1 = 8, read_reg2 = 9 give 32'h0F0F0F0F / 32'hF0F0F0F0; write_ack high for 2 cycles.
  - Then drive the operand mux with sel 0 -> mux output 32'hF0F0F0F0.
- $zero protection: reg_write = 1, write_reg = 0, write_data = 32'hFFFFFFFF -> read of reg 0 returns 0 both before and after the edge; write_ack stays 0.
- Bypass: reg 3 holds 32'h00000011; in the same cycle reg_write = 1, write_reg = 3, write_data = 32'hDEADBEEF, read_reg1 = read_reg2 = 3 -> both outputs = 32'hDEADBEEF before the edge; reg 3 = 32'hDEADBEEF after the edge.
- Write disabled: reg_write = 0, write_reg = 12, write_data = 32'h12345678 over 3 edges -> reg 12 keeps its prior value 32'h00000000; write_ack = 0.
- Reset mid-operation: reg 20 = 32'hAAAA5555, then assert reset_n = 0 between edges while reg_write = 1 targets reg 20 with 32'h1 -> reg 20 reads 0 immediately and stays 0 after release.

Source files
------------

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS general-purpose register file.
// Two combinational read ports, one clocked write port, same-cycle
// write-to-read bypass, hardwired-zero $0 and a one-cycle write_ack pulse.
module mips_register_file #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic              reg_write,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic              write_ack
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              write_ack_q;
   logic              write_ack_d;
   logic              wr_en;
   logic              bypass1;
   logic              bypass2;

   // A write only takes effect for a non-zero destination
   assign wr_en   = reg_write && (write_reg != '0);
   assign bypass1 = wr_en && (write_reg == read_reg1);
   assign bypass2 = wr_en && (write_reg == read_reg2);

   // Next-state of the register array; $0 is pinned to zero
   always_comb begin
      regs_d      = regs_q;
      write_ack_d = wr_en;
      if (wr_en) begin
         regs_d[write_reg] = write_data;
      end
      regs_d[0] = '0;
   end

   // Register array and write_ack state, cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         write_ack_q <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         write_ack_q <= write_ack_d;
      end
   end

   // Read port 1: zero during reset and for $0, bypass a matching write
   always_comb begin
      read_data1 = '0;
      if (reset_n && (read_reg1 != '0)) begin
         if (bypass1) begin
            read_data1 = write_data;
         end else begin
            read_data1 = regs_q[read_reg1];
         end
      end
   end

   // Read port 2: same rules as port 1, evaluated independently
   always_comb begin
      read_data2 = '0;
      if (reset_n && (read_reg2 != '0)) begin
         if (bypass2) begin
            read_data2 = write_data;
         end else begin
            read_data2 = regs_q[read_reg2];
         end
      end
   end

   assign write_ack = write_ack_q;

endmodule

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file: directed vector table,
// hand-written reset/mux sequences and a randomized phase against an
// array-based reference model.
module tb_mips_register_file;

   logic        clk;
   logic        reset_n;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        reg_write;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic        write_ack;

   int n_checks = 0;
   int n_fail   = 0;

   mips_register_file #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .reg_write  (reg_write),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .write_ack  (write_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] exp1;
      logic [31:0] exp2;
      logic        exp_ack;
   } vec_t;

   vec_t vecs [12];
   logic [31:0] model [32];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] mux2(input logic sel, input logic [31:0] in0, input logic [31:0] in1);
      return sel ? in1 : in0;
   endfunction

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2);
      reg_write  = we;
      write_reg  = wa;
      write_data = wd;
      read_reg1  = ra1;
      read_reg2  = ra2;
   endtask

   // Watchdog so the run always ends
   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{1'b1, 5'd8,  32'h0F0F0F0F, 5'd8,  5'd9,  32'h0F0F0F0F, 32'h00000000, 1'b1};
      vecs[1]  = '{1'b1, 5'd9,  32'hF0F0F0F0, 5'd8,  5'd9,  32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1};
      vecs[2]  = '{1'b0, 5'd0,  32'h00000000, 5'd8,  5'd9,  32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0};
      vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000, 1'b0};
      vecs[4]  = '{1'b0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000, 1'b0};
      vecs[5]  = '{1'b1, 5'd3,  32'h00000011, 5'd3,  5'd3,  32'h00000011, 32'h00000011, 1'b1};
      vecs[6]  = '{1'b1, 5'd3,  32'hDEADBEEF, 5'd3,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
      vecs[7]  = '{1'b0, 5'd12, 32'h12345678, 5'd3,  5'd12, 32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[8]  = '{1'b0, 5'd12, 32'h12345678, 5'd3,  5'd12, 32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[9]  = '{1'b0, 5'd12, 32'h12345678, 5'd3,  5'd12, 32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[10] = '{1'b1, 5'd20, 32'hAAAA5555, 5'd20, 5'd20, 32'hAAAA5555, 32'hAAAA5555, 1'b1};
      vecs[11] = '{1'b0, 5'd20, 32'h00000000, 5'd20, 5'd0,  32'hAAAA5555, 32'h00000000, 1'b0};

      // Reset held: reads and ack are zero
      reset_n = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
      #10;
      check("reset_rd1", read_data1, 32'h0);
      check("reset_rd2", read_data2, 32'h0);
      check("reset_ack", {31'b0, write_ack}, 32'h0);
      #12 reset_n = 1'b1;
      #1;
      check("release_rd1", read_data1, 32'h0);
      check("release_rd2", read_data2, 32'h0);
      check("release_ack", {31'b0, write_ack}, 32'h0);

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
         #1;
         check($sformatf("vec%0d_rd1", i), read_data1, vecs[i].exp1);
         check($sformatf("vec%0d_rd2", i), read_data2, vecs[i].exp2);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_ack", i), {31'b0, write_ack}, {31'b0, vecs[i].exp_ack});
      end

      // Operand mux fed by read_data2 (input 0) and an immediate (input 1)
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd9);
      #1;
      check("mux_sel0", mux2(1'b0, read_data2, 32'hFFFFFFFC), 32'hF0F0F0F0);
      check("mux_sel1", mux2(1'b1, read_data2, 32'hFFFFFFFC), 32'hFFFFFFFC);
      check("reg8_hold", read_data1, 32'h0F0F0F0F);

      // Reset asserted between edges while a write to reg 20 is pending
      @(negedge clk);
      drive(1'b1, 5'd20, 32'h00000001, 5'd20, 5'd8);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_rd1", read_data1, 32'h0);
      check("midrst_rd2", read_data2, 32'h0);
      @(posedge clk);
      #1;
      check("midrst_edge_rd1", read_data1, 32'h0);
      check("midrst_ack", {31'b0, write_ack}, 32'h0);
      @(negedge clk);
      reg_write = 1'b0;
      #2 reset_n = 1'b1;
      #1;
      check("postrst_rd1", read_data1, 32'h0);
      check("postrst_rd2", read_data2, 32'h0);
      @(posedge clk);
      #1;
      check("postrst_edge_rd1", read_data1, 32'h0);

      // Randomized phase against array model
      for (int r = 0; r < 32; r++) model[r] = 32'h0;
      for (int n = 0; n < 400; n++) begin
         logic        we;
         logic [4:0]  wa, ra1, ra2;
         logic [31:0] wd, e1, e2;
         logic        eack;
         @(negedge clk);
         we  = 1'($urandom_range(0, 1));
         wa  = (n % 2 == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         ra1 = (n % 3 == 0) ? wa : 5'($urandom_range(0, 7));
         ra2 = (n % 4 == 0) ? wa : 5'($urandom);
         wd  = 32'($urandom);
         drive(we, wa, wd, ra1, ra2);
         e1 = (ra1 == 0) ? 32'h0 : ((we && wa == ra1) ? wd : model[ra1]);
         e2 = (ra2 == 0) ? 32'h0 : ((we && wa == ra2) ? wd : model[ra2]);
         eack = we && (wa != 0);
         #1;
         check($sformatf("rnd%0d_rd1", n), read_data1, e1);
         check($sformatf("rnd%0d_rd2", n), read_data2, e2);
         @(posedge clk);
         if (we && wa != 0) model[wa] = wd;
         #1;
         check($sformatf("rnd%0d_ack", n), {31'b0, write_ack}, {31'b0, eack});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
